// File: rtl/csa_stream_accumulator.sv
// Carry-save multi-operand accumulator: one CSA row per beat, chunked ripple resolve at packet end.
// Latency: out_valid rises NCHUNK+1 edges after the in_last beat is accepted; optional beat count via CSA_STREAM_ACCUMULATOR_COUNT_EN.
// Backpressure: in_ready drops from the in_last beat until the result is taken; the result holds while out_ready=0.
module csa_stream_accumulator #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 24,
    parameter int CHUNK     = 8
`ifdef CSA_STREAM_ACCUMULATOR_COUNT_EN
    , parameter int COUNT_WIDTH = 16
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_sum,
`ifdef CSA_STREAM_ACCUMULATOR_COUNT_EN
    output logic [COUNT_WIDTH-1:0] out_count,
`endif
    output logic                   out_overflow
);

    localparam int NCHUNK = ACC_WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (WIDTH < 1 || CHUNK < 1 || ACC_WIDTH < WIDTH || (ACC_WIDTH % CHUNK) != 0) begin : g_param_err
            $error("csa_stream_accumulator: illegal WIDTH/ACC_WIDTH/CHUNK combination");
        end
    endgenerate

    typedef enum logic [1:0] {ST_ACC, ST_RESOLVE, ST_DONE} state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   s_q, s_d, c_q, c_d;
    logic [ACC_WIDTH-1:0]   result_q, result_d;
    logic [ACC_WIDTH-1:0]   out_sum_q, out_sum_d;
    logic [KW-1:0]          k_q, k_d;
    logic                   cin_q, cin_d;
    logic                   ovf_q, ovf_d;
    logic                   out_ovf_q, out_ovf_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
`ifdef CSA_STREAM_ACCUMULATOR_COUNT_EN
    logic [COUNT_WIDTH-1:0] count_q, count_d;
`endif

    logic [ACC_WIDTH-1:0]   operand;
    logic [ACC_WIDTH-1:0]   maj;
    logic [CHUNK:0]         chunk_sum;
    logic                   in_hs;
    logic                   out_hs;

    always_comb begin
        operand   = ACC_WIDTH'(in_data);
        maj       = (s_q & c_q) | (s_q & operand) | (c_q & operand);
        chunk_sum = {1'b0, s_q[k_q*CHUNK +: CHUNK]} + {1'b0, c_q[k_q*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, cin_q};
        in_hs     = in_valid && in_ready_q;
        out_hs    = out_valid_q && out_ready;

        state_d   = state_q;
        s_d       = s_q;
        c_d       = c_q;
        result_d  = result_q;
        out_sum_d = out_sum_q;
        k_d       = k_q;
        cin_d     = cin_q;
        ovf_d     = ovf_q;
        out_ovf_d = out_ovf_q;
`ifdef CSA_STREAM_ACCUMULATOR_COUNT_EN
        count_d   = count_q;
`endif

        case (state_q)
            ST_ACC: begin
                if (in_hs) begin
                    s_d = s_q ^ c_q ^ operand;
                    c_d = maj << 1;
                    // A majority bit in the top column carries weight 2^ACC_WIDTH and is lost.
                    if (maj[ACC_WIDTH-1]) ovf_d = 1'b1;
`ifdef CSA_STREAM_ACCUMULATOR_COUNT_EN
                    if (count_q != '1) count_d = count_q + 1'b1;
`endif
                    if (in_last) begin
                        state_d = ST_RESOLVE;
                        k_d     = '0;
                        cin_d   = 1'b0;
                    end
                end
            end
            ST_RESOLVE: begin
                result_d[k_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                cin_d = chunk_sum[CHUNK];
                k_d   = k_q + 1'b1;
                if (k_q == KW'(NCHUNK-1)) begin
                    state_d   = ST_DONE;
                    k_d       = '0;
                    ovf_d     = ovf_q | chunk_sum[CHUNK];
                    out_ovf_d = ovf_q | chunk_sum[CHUNK];
                    out_sum_d = result_d;
                end
            end
            ST_DONE: begin
                if (out_hs) begin
                    state_d = ST_ACC;
                    s_d     = '0;
                    c_d     = '0;
                    ovf_d   = 1'b0;
`ifdef CSA_STREAM_ACCUMULATOR_COUNT_EN
                    count_d = '0;
`endif
                end
            end
            default: state_d = ST_ACC;
        endcase

        in_ready_d  = (state_d == ST_ACC);
        out_valid_d = (state_q == ST_DONE) && !out_hs;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            s_q         <= '0;
            c_q         <= '0;
            result_q    <= '0;
            out_sum_q   <= '0;
            k_q         <= '0;
            cin_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_ovf_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef CSA_STREAM_ACCUMULATOR_COUNT_EN
            count_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            result_q    <= result_d;
            out_sum_q   <= out_sum_d;
            k_q         <= k_d;
            cin_q       <= cin_d;
            ovf_q       <= ovf_d;
            out_ovf_q   <= out_ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef CSA_STREAM_ACCUMULATOR_COUNT_EN
            count_q     <= count_d;
`endif
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_sum      = out_sum_q;
    assign out_overflow = out_ovf_q;
`ifdef CSA_STREAM_ACCUMULATOR_COUNT_EN
    assign out_count    = count_q;
`endif

endmodule

// File: doc/csa_stream_accumulator.md
Name: csa_stream_accumulator

Overview:
- Parametrised multi-operand accumulator built on full-adder/half-adder carry-save arithmetic.
- Accepts a stream of unsigned WIDTH-bit operands per packet and holds the running total in redundant form (sum and carry vectors), one carry-save row per beat.
- At packet end, the total is resolved to binary by a CHUNK-bit-per-cycle ripple stage. Successor to the single-bit FA/HA mapping: multi-operand, multi-cycle, with handshakes and overflow detection.

Parameters:
- WIDTH, 16, input operand width.
- ACC_WIDTH, 24, accumulator/result width; must satisfy ACC_WIDTH >= WIDTH.
- CHUNK, 8, bits resolved per cycle; ACC_WIDTH % CHUNK must be 0. NCHUNK = ACC_WIDTH/CHUNK.
- Any illegal parameter combination is an elaboration error.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand.
- in_data  in  WIDTH  unsigned operand.
- in_last  in  1  marks final operand of packet; qualified by in_valid.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  ACC_WIDTH  packet sum modulo 2^ACC_WIDTH.
- out_overflow  out  1  true sum >= 2^ACC_WIDTH.

Behaviour:
- Reset (rst=1 at edge):
  - state=ACC; S, C, result, chunk index and overflow all cleared.
  - Outputs next cycle: in_ready=1, out_valid=0, out_sum=0, out_overflow=0.
  - rst takes priority over every other event in every state; a partially accumulated or resolving packet is discarded with no residue.
- States ACC, RESOLVE, DONE.
- ACC: in_ready=1, out_valid=0.
  - On handshake (in_valid & in_ready), operand D = zero-extended in_data.
  - Update: S' = S^C^D; C' = (maj(S,C,D)) << 1, truncated to ACC_WIDTH.
  - Any nonzero maj bit at position ACC_WIDTH-1 sets the sticky overflow flag.
  - If in_last was set on the handshake: next state RESOLVE, chunk index k=0, carry-in=0.
  - Zero-length packets do not exist; the first beat may carry in_last.
- RESOLVE: in_ready=0, out_valid=0.
  - Each cycle: result[k*CHUNK +: CHUNK] = S_chunk + C_chunk + cin; the chunk carry-out becomes the next cin; k increments.
  - After chunk NCHUNK-1: a final carry-out of 1 sets overflow; next state DONE.
  - Takes exactly NCHUNK cycles.
- DONE: out_valid=1, in_ready=0.
  - out_sum and out_overflow are stable while out_valid=1 and out_ready=0.
  - On out_ready: S, C and overflow are cleared; next state ACC. in_ready=1 in the following cycle, with no bubble beyond that.
- Latency: out_valid rises NCHUNK+1 clock edges after the edge that accepts the in_last beat.
- Overflow is exact because all operands are non-negative: overflow=1 iff any carry weight of 2^ACC_WIDTH was dropped, either during carry-save or at final resolve.
- out_sum retains its last value outside DONE; it is not valid unless out_valid=1.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Optional Feature:
- Macro CSA_STREAM_ACCUMULATOR_COUNT_EN.
- When defined:
  - Adds parameter COUNT_WIDTH (default 16).
  - Adds output out_count [COUNT_WIDTH]: number of beats accepted in the packet, saturating at 2^COUNT_WIDTH-1.
  - The count is reset to 0 by rst and on the DONE handshake, and is valid with out_valid.
- When undefined: no port, no counter logic; all other behaviour identical.

Test Plan:
- Defaults. Four beats 0xFFFF, in_last on 4th -> out_sum=0x03FFFC, out_overflow=0; out_valid asserts exactly 4 edges after the last handshake.
- Single beat 0x1234 with in_last -> out_sum=0x001234, overflow=0. Then a back-to-back packet 5,7 -> out_sum=0x00000C, showing no residue from the prior packet.
- Overflow. 257 beats of 0xFFFF -> out_sum=0x00FEFF, out_overflow=1. The next packet, single beat 1 -> out_sum=1, out_overflow=0 (sticky flag cleared).
- Backpressure. Hold out_ready=0 for 10 cycles in DONE -> out_valid=1, out_sum/out_overflow constant, in_ready=0 throughout. Then out_ready=1 for one cycle -> out_valid=0 and in_ready=1 next cycle.
- Reset mid-operation. Assert rst during the 2nd RESOLVE cycle -> next cycle in_ready=1, out_valid=0, out_sum=0. A following packet 3,4 -> out_sum=7.
- Macro defined. A 4-beat packet -> out_count=4. A 1-beat packet -> out_count=1.
